bank_read_streamer: RTL

Read-side sequencer for one memory_bank instance. On a start command it issues a run of consecutive reads (base, base+1, …) to the bank's read port and absorbs the bank's 1-cycle read latency. It delivers the words in order on a valid/ready stream toward the PE array feeder, with an internal 4-entry buffer so downstream backpressure never drops or duplicates a word.

---
 rtl/bank_read_streamer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/bank_read_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : bank_read_streamer
//  Purpose  : Read-side sequencer for one memory bank. A start command issues
//             a run of consecutive reads (base, base+1, ... wrapping at the top
//             of the bank), absorbs the bank's 1-cycle read latency and streams
//             the words in order on a valid/ready interface through a 4-entry
//             buffer, so downstream backpressure never drops or repeats a word.
//  Ports    : clk, rst (async, active-high)
//             start, base_addr, length   - command (accepted only when idle)
//             busy, done                 - command status / completion pulse
//             re, rd_addr, rd_data       - bank read port (1-cycle latency)
//             out_valid, out_ready,
//             out_data, out_last         - output word stream
//  Revision : 1.0 - initial release
// ============================================================================
module bank_read_streamer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              re,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int          FIFO_DEPTH   = 4;
  localparam logic [3:0]  C_FIFO_DEPTH = 4'd4;
  localparam logic [ADDR_W:0]   C_LEN_ZERO = '0;
  localparam logic [ADDR_W:0]   C_LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic [ADDR_W:0]   r_remaining;   // reads still to be issued
  logic              r_re;          // read issued this cycle
  logic              r_re_last;     // ... and it is the final address
  logic              r_rv;          // rd_data valid this cycle
  logic              r_rv_last;     // ... and it is the final word
  logic [ADDR_W-1:0] r_rd_addr;

  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_last;
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_occ;

  logic              w_start_cmd;
  logic              w_push;
  logic              w_pop;
  logic [3:0]        w_inflight;
  logic              w_issue;
  logic              w_drained;

  assign w_start_cmd = (r_state == S_IDLE) && start;
  assign w_push      = r_rv;
  assign w_pop       = (r_occ != 3'd0) && out_ready;

  // Words already committed to the buffer: stored, arriving now, or in the
  // bank pipeline. Only registered terms, so out_ready never reaches re.
  assign w_inflight  = {1'b0, r_occ} + {3'b000, r_re} + {3'b000, r_rv};
  assign w_issue     = (r_state == S_RUN) && (r_remaining != C_LEN_ZERO) &&
                       (w_inflight < C_FIFO_DEPTH);

  // Buffer will be empty after this edge and nothing remains in the bank
  // pipeline; lets done land the cycle right after the last handshake.
  assign w_drained   = !r_re && !r_rv &&
                       ((r_occ == 3'd0) || ((r_occ == 3'd1) && w_pop));

  // ---------------------------------------------------------------- FSM ---
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (length == C_LEN_ZERO) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_remaining == C_LEN_ZERO) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drained) begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN, S_DRAIN: busy = 1'b1;
      S_DONE:         done = 1'b1;
      default:        ;
    endcase
  end

  // ------------------------------------------------------- read issuing ---
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_re        <= 1'b0;
      r_re_last   <= 1'b0;
      r_rv        <= 1'b0;
      r_rv_last   <= 1'b0;
      r_rd_addr   <= '0;
      r_remaining <= '0;
    end else begin
      // The first read goes out straight from the start command so that
      // re rises in the cycle after start is sampled.
      if (w_start_cmd && (length != C_LEN_ZERO)) begin
        r_re        <= 1'b1;
        r_re_last   <= (length == C_LEN_ONE);
        r_rd_addr   <= base_addr;
        r_remaining <= length - C_LEN_ONE;
      end else if (w_issue) begin
        r_re        <= 1'b1;
        r_re_last   <= (r_remaining == C_LEN_ONE);
        r_rd_addr   <= r_rd_addr + C_ADDR_ONE;  // wraps naturally
        r_remaining <= r_remaining - C_LEN_ONE;
      end else begin
        r_re        <= 1'b0;
        r_re_last   <= 1'b0;
      end
      r_rv      <= r_re;
      r_rv_last <= r_re && r_re_last;
    end
  end

  assign re      = r_re;
  assign rd_addr = r_rd_addr;

  // ------------------------------------------------------ output buffer ---
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
      end
      r_fifo_last <= '0;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_occ       <= 3'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= rd_data;
        r_fifo_last[r_wr_ptr] <= r_rv_last;
        r_wr_ptr              <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 3'd1;
        2'b01:   r_occ <= r_occ - 3'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign out_valid = (r_occ != 3'd0);
  assign out_data  = r_fifo_data[r_rd_ptr];
  assign out_last  = out_valid && r_fifo_last[r_rd_ptr];

endmodule
`default_nettype wire
